// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter in front of the JTAG-UART transmit port.
// Grants are line-atomic and alternate round-robin between requester A
// (console) and requester B (board messages). A grant ends on an accepted
// EOL byte, after MAX_BURST bytes, or after IDLE_TIMEOUT idle cycles.
// The byte towards the UART sits in a one-deep output register.
//
// Handshake rule on every port: a byte moves on a rising clock edge
// exactly when valid and ready are both high in the preceding cycle.
// A producer may withdraw valid before it is accepted. The arbiter never
// withdraws tx_valid and never changes tx_data while tx_ready is low.
module uart_tx_arbiter #(
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] EOL          = 8'h0A
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [7:0] b_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [1:0] owner
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  // Encoding equals the owner code, so the state register is the owner output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t         state, state_nxt;
  logic           last_b, last_b_nxt;   // 1: B was served last
  logic [BW-1:0]  burst_cnt, burst_nxt;
  logic [IW-1:0]  idle_cnt, idle_nxt;
  logic           slot_free;            // output register can take a byte
  logic           own_valid;
  logic [7:0]     own_data;
  logic           accept;
  logic           release_now;

  assign slot_free = ~tx_valid | tx_ready;
  assign owner     = state;

  // Arbitration, grant release and per-grant counters.
  always_comb begin
    state_nxt   = state;
    last_b_nxt  = last_b;
    burst_nxt   = burst_cnt;
    idle_nxt    = idle_cnt;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    own_valid   = 1'b0;
    own_data    = a_data;
    accept      = 1'b0;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        // Counters start from zero on every fresh grant.
        burst_nxt = '0;
        idle_nxt  = '0;
        if (a_valid && (!b_valid || last_b)) state_nxt = OWN_A;
        else if (b_valid)                    state_nxt = OWN_B;
      end
      OWN_A: begin
        own_valid = a_valid;
        own_data  = a_data;
        a_ready   = slot_free;
      end
      OWN_B: begin
        own_valid = b_valid;
        own_data  = b_data;
        b_ready   = slot_free;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == OWN_A || state == OWN_B) begin
      accept   = own_valid & slot_free;
      idle_nxt = own_valid ? '0 : idle_cnt + IW'(1);
      if (accept) burst_nxt = burst_cnt + BW'(1);
      // EOL and the last burst byte can coincide; both just end the grant.
      release_now = (accept && (own_data == EOL || burst_cnt == BW'(MAX_BURST - 1)))
                 || (!own_valid && idle_cnt == IW'(IDLE_TIMEOUT - 1));
      if (release_now) begin
        state_nxt  = IDLE;
        last_b_nxt = (state == OWN_B);
      end
    end
  end

  // State, pointer, counters and the registered output byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state     <= state_nxt;
      last_b    <= last_b_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= own_data;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized rounds.
// Expected output is built from the source byte queues by splitting each
// stream into lines/bursts and alternating between the two streams.
module tb_uart_tx_arbiter;

  localparam int         MAX_BURST    = 4;
  localparam int         IDLE_TIMEOUT = 16;
  localparam logic [7:0] EOL          = 8'h0A;
  localparam int         HN           = 256;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_data, b_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] owner;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .MAX_BURST   (MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .EOL         (EOL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .owner   (owner)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  int         got_len_q[$];
  int         cyc, stall_lo, stall_hi, ready_pct, cur_len;
  logic       prev_v, prev_r;
  logic [7:0] prev_d;
  logic [1:0] prev_owner;
  logic [1:0] hist_owner[HN];
  logic       hist_txv[HN];
  logic       hist_ar[HN];
  logic [7:0] hist_txd[HN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Split both streams into grants (end after EOL or MAX_BURST bytes) and
  // serve them alternately, A first after reset; a stream with nothing
  // left is skipped, so the other one simply continues.
  task automatic build_model();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] byte_v;
    bit         turn_b, sel_b;
    int         len;
    qa = a_q;
    qb = b_q;
    turn_b = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    while (qa.size() > 0 || qb.size() > 0) begin
      sel_b = (qb.size() > 0) && (turn_b || qa.size() == 0);
      len = 0;
      do begin
        byte_v = sel_b ? qb.pop_front() : qa.pop_front();
        exp_q.push_back(byte_v);
        len++;
      end while (byte_v != EOL && len < MAX_BURST && (sel_b ? qb.size() : qa.size()) > 0);
      exp_len_q.push_back(len);
      turn_b = !sel_b;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    a_valid  = (a_q.size() > 0);
    a_data   = a_valid ? a_q[0] : 8'h00;
    b_valid  = (b_q.size() > 0);
    b_data   = b_valid ? b_q[0] : 8'h00;
    tx_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0
             : ($urandom_range(99) < ready_pct);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    exp_len_q.delete();
    got_len_q.delete();
    cyc = 0; cur_len = 0; stall_lo = 0; stall_hi = 0; ready_pct = 100;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00; prev_owner = 2'b00;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00; tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock: sample mid-cycle, score outputs, then update inputs.
  task automatic cycle();
    bit          a_acc, b_acc;
    logic [31:0] want;
    @(negedge clock);
    if (cyc < HN) begin
      hist_owner[cyc] = owner;
      hist_txv[cyc]   = tx_valid;
      hist_ar[cyc]    = a_ready;
      hist_txd[cyc]   = tx_data;
    end
    if (prev_v && !prev_r) begin
      check_val("hold_valid", 32'(tx_valid), 32'd1);
      check_val("hold_data", 32'(tx_data), 32'(prev_d));
    end
    check_val("ready_excl", 32'(a_ready & b_ready), 32'd0);
    if (tx_valid && tx_ready) begin
      want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h1FF;
      check_val("tx_byte", 32'(tx_data), want);
    end
    if (prev_owner != 2'b00 && owner == 2'b00) begin
      got_len_q.push_back(cur_len);
      cur_len = 0;
    end
    a_acc = a_valid && a_ready;
    b_acc = b_valid && b_ready;
    if (a_acc || b_acc) cur_len++;
    prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_owner = owner;
    @(posedge clock);
    #1;
    if (a_acc) void'(a_q.pop_front());
    if (b_acc) void'(b_q.pop_front());
    cyc++;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || tx_valid || owner != 2'b00) && n < budget) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    check_val("drain_in_budget", 32'(n < budget), 32'd1);
    check_val("bytes_left", 32'(exp_q.size()), 32'd0);
    check_val("grant_count", 32'(got_len_q.size()), 32'(exp_len_q.size()));
    for (int i = 0; i < got_len_q.size() && i < exp_len_q.size(); i++)
      check_val("grant_len", 32'(got_len_q[i]), 32'(exp_len_q[i]));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // Reset state.
    do_reset();
    check_val("rst_owner", 32'(owner), 32'd0);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_a_ready", 32'(a_ready), 32'd0);
    check_val("rst_b_ready", 32'(b_ready), 32'd0);

    // "HI\n" from A only, UART always ready.
    do_reset();
    a_q = '{8'h48, 8'h49, 8'h0A};
    build_model();
    drive();
    run_until_done(200);
    check_val("hi_owner1", 32'(hist_owner[1]), 32'd1);
    check_val("hi_txv1", 32'(hist_txv[1]), 32'd0);
    check_val("hi_byte0", 32'(hist_txd[2]), 32'h48);
    check_val("hi_byte1", 32'(hist_txd[3]), 32'h49);
    check_val("hi_byte2", 32'(hist_txd[4]), 32'h0A);
    check_val("hi_txv4", 32'(hist_txv[4]), 32'd1);
    check_val("hi_owner3", 32'(hist_owner[3]), 32'd1);
    check_val("hi_owner4", 32'(hist_owner[4]), 32'd0);
    check_val("hi_txv5", 32'(hist_txv[5]), 32'd0);

    // Both valid from reset: A's line, one idle cycle, then B's line.
    do_reset();
    a_q = '{8'h78, 8'h0A};
    b_q = '{8'h78, 8'h0A};
    build_model();
    drive();
    run_until_done(200);
    check_val("tie_owner1", 32'(hist_owner[1]), 32'd1);
    check_val("tie_owner3", 32'(hist_owner[3]), 32'd0);
    check_val("tie_owner4", 32'(hist_owner[4]), 32'd2);

    // UART stalls for 5 cycles right after A's first byte.
    do_reset();
    a_q = '{8'h53, 8'h54, 8'h0A};
    stall_lo = 2;
    stall_hi = 7;
    build_model();
    drive();
    run_until_done(200);
    for (int k = 2; k < 7; k++) begin
      check_val("stall_a_ready", 32'(hist_ar[k]), 32'd0);
      check_val("stall_txv", 32'(hist_txv[k]), 32'd1);
      check_val("stall_txd", 32'(hist_txd[k]), 32'h53);
    end

    // Burst limit: 10 A bytes without EOL while B waits with a line.
    do_reset();
    for (int i = 0; i < 10; i++) a_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
    b_q = '{8'h42, 8'h31, 8'h0A};
    build_model();
    drive();
    run_until_done(400);
    check_val("burst_len0", 32'(got_len_q.size() > 0 ? got_len_q[0] : -1), 32'd4);
    check_val("burst_len1", 32'(got_len_q.size() > 1 ? got_len_q[1] : -1), 32'd3);
    check_val("burst_len2", 32'(got_len_q.size() > 2 ? got_len_q[2] : -1), 32'd4);
    check_val("burst_len3", 32'(got_len_q.size() > 3 ? got_len_q[3] : -1), 32'd2);

    // Idle timeout: A sends one byte then goes quiet while B waits.
    do_reset();
    a_q = '{8'h41};
    b_q = '{8'h42, 8'h0A};
    build_model();
    drive();
    run_until_done(200);
    check_val("idle_owner17", 32'(hist_owner[17]), 32'd1);
    check_val("idle_owner18", 32'(hist_owner[18]), 32'd0);
    check_val("idle_owner19", 32'(hist_owner[19]), 32'd2);

    // Reset in the middle of a stalled B grant, after A was served last.
    do_reset();
    a_q = '{8'h61, 8'h0A};
    b_q = '{8'h62, 8'h63, 8'h64, 8'h0A};
    stall_lo = 5;
    stall_hi = 1000;
    build_model();
    drive();
    repeat (8) cycle();
    check_val("mid_owner4", 32'(hist_owner[4]), 32'd2);
    check_val("mid_txv7", 32'(hist_txv[7]), 32'd1);
    check_val("mid_txd7", 32'(hist_txd[7]), 32'h62);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_val("mid_rst_txv", 32'(tx_valid), 32'd0);
    check_val("mid_rst_owner", 32'(owner), 32'd0);
    check_val("mid_rst_a_ready", 32'(a_ready), 32'd0);
    check_val("mid_rst_b_ready", 32'(b_ready), 32'd0);
    do_reset();
    a_q = '{8'h71, 8'h0A};
    b_q = '{8'h72, 8'h0A};
    build_model();
    drive();
    run_until_done(200);
    check_val("post_rst_tie", 32'(hist_owner[1]), 32'd1);

    // Randomized rounds: random lines, random UART back-pressure.
    for (int r = 0; r < 20; r++) begin
      int na, nb;
      do_reset();
      ready_pct = $urandom_range(30, 100);
      na = $urandom_range(0, 12);
      nb = $urandom_range(0, 12);
      for (int i = 0; i < na; i++)
        a_q.push_back(($urandom_range(0, 4) == 0) ? EOL : 8'($urandom_range(0, 255)));
      for (int i = 0; i < nb; i++)
        b_q.push_back(($urandom_range(0, 4) == 0) ? EOL : 8'($urandom_range(0, 255)));
      build_model();
      drive();
      run_until_done(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
